imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pipe.sv | 152 +++++++++++++++
 tb/tb_imm_ext_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pipe
// Description : Immediate-extension unit with a two-entry output pipeline.
//               A raw IMM_W-bit immediate is zero/sign/ones-extended, placed
//               as an upper load, or turned into a word-aligned branch offset,
//               according to extop. Results leave through a main output
//               register backed by a skid register, so the unit can take one
//               request per cycle and absorb one cycle of consumer stall.
//               Illegal extops produce a zero result flagged with out_err
//               and are counted in a saturating counter.
// Ports       : clk        - single rising-edge clock
//               rst_n      - asynchronous active-low reset
//               flush      - synchronous flush of both entries and the input
//               in_valid   - request valid
//               in_ready   - registered; low only while the skid entry is full
//               imm        - raw immediate, IMM_W bits
//               extop      - extension mode (3 bits)
//               out_valid  - result valid (from main register)
//               out_ready  - consumer accepts result
//               out_data   - extended result, DATA_W bits
//               out_err    - result came from an illegal extop
//               err_cnt    - saturating count of accepted illegal extops
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe #(
    parameter int IMM_W  = 16,   // must satisfy 2 <= IMM_W < DATA_W
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        extop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int         c_PAD       = DATA_W - IMM_W;
    localparam logic [2:0] c_OP_ZERO   = 3'b000;
    localparam logic [2:0] c_OP_SIGN   = 3'b001;
    localparam logic [2:0] c_OP_UPPER  = 3'b010;
    localparam logic [2:0] c_OP_BRANCH = 3'b011;
    localparam logic [2:0] c_OP_ONES   = 3'b100;

    // Main (output) entry
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_main_err;
    // Skid entry
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_err;

    logic              r_in_ready;
    logic [CNT_W-1:0]  r_err_cnt;

    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_ext;
    logic              w_illegal;
    logic              w_accept;
    logic              w_main_free;

    // ------------------------------------------------------------------
    // Extension datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_sext    = {{c_PAD{imm[IMM_W-1]}}, imm};
        w_ext     = '0;
        w_illegal = 1'b0;
        case (extop)
            c_OP_ZERO:   w_ext = {{c_PAD{1'b0}}, imm};
            c_OP_SIGN:   w_ext = w_sext;
            c_OP_UPPER:  w_ext = {imm, {c_PAD{1'b0}}};
            c_OP_BRANCH: w_ext = {w_sext[DATA_W-3:0], 2'b00};
            c_OP_ONES:   w_ext = {{c_PAD{1'b1}}, imm};
            default: begin
                w_ext     = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // in_ready mirrors !skid_valid, so an accepted request never meets a
    // full skid entry.
    assign w_accept    = in_valid & r_in_ready & ~flush;
    // Main can take new data if it is empty or is being drained this edge.
    assign w_main_free = ~r_main_valid | out_ready;

    // ------------------------------------------------------------------
    // Pipeline registers and error counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_err   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_err_cnt    <= '0;
        end else if (flush) begin
            // Both entries and any concurrent request are dropped; the
            // counter keeps its value.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_main_free) begin
                if (r_skid_valid) begin
                    // Older skid entry goes first to keep acceptance order.
                    r_main_valid <= 1'b1;
                    r_main_data  <= r_skid_data;
                    r_main_err   <= r_skid_err;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (w_accept) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= w_ext;
                    r_main_err   <= w_illegal;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                // Main is stalled with data: park the result in the skid.
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_ext;
                r_skid_err   <= w_illegal;
                r_in_ready   <= 1'b0;
            end

            if (w_accept && w_illegal && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_err   = r_main_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_ext_pipe
// Description : Scoreboard bench for imm_ext_pipe. A reference model computes
//               each extension with plain arithmetic; expected results are
//               queued on acceptance and popped by the monitor on transfer.
//               A second instance with a 2-bit counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  extop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [7:0]  err_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic        s_out_err;
    logic [1:0]  s_err_cnt;

    int checks   = 0;
    int failures = 0;

    logic [32:0] q[$];      // {err, data} of results held inside the DUT
    int          m_cnt  = 0;
    int          m_cnt2 = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.IMM_W(16), .DATA_W(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .imm(imm), .extop(extop), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .err_cnt(err_cnt)
    );

    imm_ext_pipe #(.IMM_W(16), .DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(s_in_ready), .imm(imm), .extop(extop), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_err(s_out_err),
        .err_cnt(s_err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension using modular arithmetic on the immediate value.
    function automatic logic [32:0] ref_ext(input logic [15:0] i, input logic [2:0] op);
        longint unsigned iv, s, m, half, full;
        m    = 64'd1 << DATA_W;
        full = 64'd1 << IMM_W;
        half = 64'd1 << (IMM_W - 1);
        iv   = longint'(i);
        s    = (iv >= half) ? (iv + m - full) : iv;
        case (op)
            3'd0:    return {1'b0, 32'(iv)};
            3'd1:    return {1'b0, 32'(s)};
            3'd2:    return {1'b0, 32'((iv * (64'd1 << (DATA_W - IMM_W))) % m)};
            3'd3:    return {1'b0, 32'((s * 4) % m)};
            3'd4:    return {1'b0, 32'(iv + m - full)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Monitor: compares DUT state against the model between edges, then
    // advances the model by what happens at the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (out_valid && q.size() > 0) begin
                chk("out_data", 64'(out_data), 64'(q[0][31:0]));
                chk("out_err", 64'(out_err), 64'(q[0][32]));
            end
            chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
            chk("err_cnt_sat", 64'(s_err_cnt), 64'(m_cnt2));
            if (flush) begin
                q.delete();
            end else begin
                logic acc;
                acc = in_valid && (q.size() < 2);
                if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
                if (acc) begin
                    q.push_back(ref_ext(imm, extop));
                    if (extop > 3'd4) begin
                        if (m_cnt < 255) m_cnt++;
                        if (m_cnt2 < 3) m_cnt2++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] i, input logic [2:0] op);
        in_valid = 1'b1;
        imm      = i;
        extop    = op;
        for (int n = 0; n < 20 && !in_ready; n++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] sweep_exp[6];
    logic [2:0]  sweep_op[6];
    logic [7:0]  cnt_save;

    initial begin
        sweep_exp = '{32'h00008001, 32'hFFFF8001, 32'h80010000,
                      32'hFFFE0004, 32'hFFFF8001, 32'h00000000};
        sweep_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; imm = '0; extop = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Mode sweep: each result visible one cycle after acceptance
        for (int k = 0; k < 6; k++) begin
            send(16'h8001, sweep_op[k]);
            chk("sweep_valid", 64'(out_valid), 64'd1);
            chk("sweep_data", 64'(out_data), 64'(sweep_exp[k]));
            chk("sweep_err", 64'(out_err), 64'(k == 5));
        end
        chk("sweep_err_cnt", 64'(err_cnt), 64'd1);
        @(posedge clk); #1;

        // Back-pressure
        out_ready = 1'b0;
        send(16'h0001, 3'd0);
        send(16'h0002, 3'd0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_hold_a", 64'(out_data), 64'h1);
        @(posedge clk); #1;
        chk("bp_hold_a2", 64'(out_data), 64'h1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_b_next", 64'(out_data), 64'h2);
        chk("bp_in_ready_high", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush with both entries full and a concurrent illegal request
        out_ready = 1'b0;
        send(16'h1234, 3'd1);
        send(16'h5678, 3'd7);
        cnt_save  = err_cnt;
        in_valid = 1'b1; imm = 16'hFFFF; extop = 3'd5; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_err_cnt", 64'(err_cnt), 64'(cnt_save));
        @(posedge clk); #1;
        chk("flush_no_stale", 64'(out_valid), 64'd0);

        // Streaming back-to-back
        for (int k = 0; k < 100; k++) send(16'($urandom), 3'($urandom_range(0, 7)));
        @(posedge clk); #1;

        // Random traffic with stalls and occasional flushes
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            imm       = 16'($urandom);
            extop     = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset between edges while a result is held
        out_ready = 1'b0;
        send(16'h00AA, 3'd6);
        chk("arst_pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;

        // Counter saturation on the 2-bit instance
        for (int k = 0; k < 5; k++) begin
            send(16'(k), 3'd7);
            chk("sat_cnt", 64'(s_err_cnt), 64'((k < 3) ? k + 1 : 3));
        end
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
